// File: rtl/branch_predictor.sv
// Branch target buffer with a 2-bit saturating direction counter per entry.
// Optional macro BRANCH_PREDICTOR_STATS_EN adds resolved/mispredicted branch counters.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_predicted,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] restore_pc
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
`endif
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];

    logic [IDXW-1:0] f_idx, u_idx;
    logic [TAGW-1:0] f_tag, u_tag;
    logic            f_hit, u_hit;

    assign f_idx = fetch_pc[IDXW+1:2];
    assign f_tag = fetch_pc[31:IDXW+2];
    assign u_idx = update_pc[IDXW+1:2];
    assign u_tag = update_pc[31:IDXW+2];
    assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

    // Lookup reads the pre-update table; a same-cycle update is not bypassed.
    always_comb begin
        predict_taken  = f_hit && ctr[f_idx][1];
        predict_target = f_hit ? target[f_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        mispredict = 1'b0;
        restore_pc = '0;
        if (update_en) begin
            mispredict = (update_predicted != update_taken) ||
                         (update_taken && update_predicted &&
                          (update_pred_target != update_target));
            restore_pc = update_taken ? update_target : update_pc + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (update_en) begin
            if (u_hit) begin
                if (update_taken) begin
                    if (ctr[u_idx] != 2'b11)
                        ctr[u_idx] <= ctr[u_idx] + 2'd1;
                    target[u_idx] <= update_target;
                end else if (ctr[u_idx] != 2'b00) begin
                    ctr[u_idx] <= ctr[u_idx] - 2'd1;
                end
            end else if (update_taken) begin
                // Allocation evicts whatever aliased into this index.
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= update_target;
                ctr[u_idx]    <= 2'b10;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (update_en) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (mispredict)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// updates against a per-index reference model of the BTB.
module tb_branch_predictor;
    localparam int ENTRIES = 16;
    localparam int IDXW    = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_predicted = 1'b0;
    logic [31:0] update_pred_target = '0;
    logic        mispredict;
    logic [31:0] restore_pc;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branch_cnt, mispredict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_predicted(update_predicted),
        .update_pred_target(update_pred_target),
        .mispredict(mispredict), .restore_pc(restore_pc)
`ifdef BRANCH_PREDICTOR_STATS_EN
        , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: each slot remembers the full branch PC it holds.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          exp_br = 0;
    int          exp_mp = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDXW + 2)) == (b >> (IDXW + 2));
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        exp_br = 0;
        exp_mp = 0;
    endfunction

    function automatic void m_look(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int s = slot(pc);
        bit hit = m_valid[s] && same_tag(m_pc[s], pc);
        tk = hit && (m_ctr[s] >= 2);
        tg = hit ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        int s = slot(pc);
        bit hit = m_valid[s] && same_tag(m_pc[s], pc);
        if (hit && tk) begin
            m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
            m_tgt[s] = tg;
        end else if (hit) begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end else if (tk) begin
            m_valid[s] = 1; m_pc[s] = pc; m_tgt[s] = tg; m_ctr[s] = 2;
        end
    endfunction

    task automatic check_lookup(input logic [31:0] pc, input string nm);
        logic        etk;
        logic [31:0] etg;
        @(negedge CLK);
        fetch_pc = pc;
        #1;
        m_look(pc, etk, etg);
        checks++;
        if (predict_taken !== etk || predict_target !== etg) begin
            errors++;
            $display("FAIL %s lookup pc=%h: got taken=%b target=%h, want taken=%b target=%h",
                     nm, pc, predict_taken, predict_target, etk, etg);
        end
        checks++;
        if (mispredict !== 1'b0 || restore_pc !== 32'd0) begin
            errors++;
            $display("FAIL %s idle: got mispredict=%b restore=%h, want 0/0", nm, mispredict, restore_pc);
        end
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                             input logic pred, input logic [31:0] ptg, input string nm);
        logic        etk, emp;
        logic [31:0] etg, ers;
        @(negedge CLK);
        fetch_pc = pc;
        update_pc = pc; update_taken = tk; update_target = tg;
        update_predicted = pred; update_pred_target = ptg;
        update_en = 1'b1;
        #1;
        emp = (pred != tk) || (tk && pred && ptg != tg);
        ers = tk ? tg : pc + 32'd4;
        m_look(pc, etk, etg);
        checks++;
        if (mispredict !== emp || restore_pc !== ers) begin
            errors++;
            $display("FAIL %s resolve pc=%h: got mispredict=%b restore=%h, want %b/%h",
                     nm, pc, mispredict, restore_pc, emp, ers);
        end
        checks++;
        if (predict_taken !== etk || predict_target !== etg) begin
            errors++;
            $display("FAIL %s same-cycle lookup pc=%h: got %b/%h, want %b/%h",
                     nm, pc, predict_taken, predict_target, etk, etg);
        end
        @(posedge CLK);
        m_update(pc, tk, tg);
        exp_br++;
        if (emp) exp_mp++;
        #1;
        update_en = 1'b0;
    endtask

    task automatic check_stats(input string nm);
`ifdef BRANCH_PREDICTOR_STATS_EN
        #1;
        checks++;
        if (branch_cnt !== 32'(exp_br) || mispredict_cnt !== 32'(exp_mp)) begin
            errors++;
            $display("FAIL %s stats: got branch=%0d mispredict=%0d, want %0d/%0d",
                     nm, branch_cnt, mispredict_cnt, exp_br, exp_mp);
        end
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic test_reset();
        m_clear();
        nRST = 1'b0;
        fetch_pc = 32'h40;
        #3;
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44 || mispredict !== 1'b0 || restore_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: got taken=%b target=%h mp=%b restore=%h, want 0/00000044/0/0",
                     predict_taken, predict_target, mispredict, restore_pc);
        end
        check_stats("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        check_lookup(32'h40, "post_reset");
    endtask

    task automatic test_allocate();
        do_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, "alloc");
        check_lookup(32'h40, "alloc_hit");
        checks++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_direct: got %b/%h, want 1/00000100", predict_taken, predict_target);
        end
    endtask

    task automatic test_counter();
        for (int i = 0; i < 3; i++) begin
            do_update(32'h40, 1'b0, 32'h0, predict_taken, predict_target, "ctr_down");
            check_lookup(32'h40, "ctr_down");
        end
        for (int i = 0; i < 4; i++) begin
            do_update(32'h40, 1'b1, 32'h100, predict_taken, predict_target, "ctr_up");
            check_lookup(32'h40, "ctr_up");
        end
        for (int i = 0; i < 2; i++) begin
            do_update(32'h40, 1'b0, 32'h0, predict_taken, predict_target, "ctr_sat_down");
            check_lookup(32'h40, "ctr_sat_down");
        end
    endtask

    task automatic test_alias();
        do_update(32'h80, 1'b1, 32'h180, 1'b0, 32'h0, "alias");
        check_lookup(32'h40, "alias_old_miss");
        check_lookup(32'h80, "alias_new_hit");
    endtask

    task automatic test_target_wrong();
        do_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0, "tw_alloc");
        do_update(32'h40, 1'b1, 32'h200, 1'b1, 32'h100, "target_wrong");
        check_lookup(32'h40, "target_wrong_after");
        do_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, "wrap_restore");
        check_lookup(32'hFFFF_FFFC, "wrap_lookup");
    endtask

    task automatic test_random();
        logic        etk;
        logic [31:0] etg, pc, tg, ptg;
        logic        tk, pred;
        for (int i = 0; i < 300; i++) begin
            pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            tk = 1'($urandom_range(0, 1));
            tg = $urandom_range(0, 3) << 8;
            m_look(pc, etk, etg);
            pred = ($urandom_range(0, 3) == 0) ? ~etk : etk;
            ptg  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : etg;
            do_update(pc, tk, tg, pred, ptg, "random");
            if (i % 4 == 0)
                check_lookup(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2), "random_lookup");
        end
        check_stats("random");
    endtask

    task automatic test_stats();
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        m_clear();
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0 && i > 0)
                do_update(32'h200 + 32'(i * 4), 1'b1, 32'h400, 1'b0, 32'h0, "stats_mp");
            else
                do_update(32'h200 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 32'h0, "stats_ok");
        end
        check_stats("stats_10_3");
    endtask

    task automatic test_reset_midrun();
        do_update(32'h300, 1'b1, 32'h500, 1'b0, 32'h0, "mid_fill");
        check_lookup(32'h300, "mid_fill_hit");
        @(negedge CLK);
        fetch_pc = 32'h340;
        update_pc = 32'h340; update_taken = 1'b1; update_target = 32'h600;
        update_predicted = 1'b0; update_pred_target = 32'h0;
        update_en = 1'b1;
        #2;
        nRST = 1'b0;
        m_clear();
        #1;
        checks++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h344) begin
            errors++;
            $display("FAIL midrun_async_clear: got %b/%h, want 0/00000344", predict_taken, predict_target);
        end
        check_stats("midrun_reset");
        @(posedge CLK);
        #1;
        update_en = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        check_lookup(32'h340, "midrun_dropped");
        check_lookup(32'h300, "midrun_cleared");
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_target_wrong();
        test_random();
        test_stats();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
